// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester above last_grant, wrapping.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          found,
    output logic [IW-1:0] index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        // Scan farthest-first so the nearest requester after last_grant wins.
        for (int k = N; k >= 1; k--) begin
            if (req[IW'((int'(last_grant) + k) % N)]) begin
                found = 1'b1;
                index = IW'((int'(last_grant) + k) % N);
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream inputs onto one output.
// The grant is held from arbitration until the beat carrying tlast is accepted.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_DEST_WIDTH = 1,
    parameter int AXI_USER_WIDTH = 1,
    localparam int IW            = idx_width(NUM_SRC),
    localparam int KW            = AXI_DATA_WIDTH / 8
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [NUM_SRC-1:0]                   src_enable,

    input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0]    s_tdata,
    input  logic [NUM_SRC*KW-1:0]                s_tkeep,
    input  logic [NUM_SRC*AXI_DEST_WIDTH-1:0]    s_tdest,
    input  logic [NUM_SRC*AXI_USER_WIDTH-1:0]    s_tuser,
    input  logic [NUM_SRC-1:0]                   s_tvalid,
    input  logic [NUM_SRC-1:0]                   s_tlast,
    output logic [NUM_SRC-1:0]                   s_tready,

    output logic [AXI_DATA_WIDTH-1:0]            m_tdata,
    output logic [KW-1:0]                        m_tkeep,
    output logic [AXI_ID_WIDTH-1:0]              m_tid,
    output logic [AXI_DEST_WIDTH-1:0]            m_tdest,
    output logic [AXI_USER_WIDTH-1:0]            m_tuser,
    output logic                                 m_tvalid,
    output logic                                 m_tlast,
    input  logic                                 m_tready,

    output logic                                 grant_valid,
    output logic [IW-1:0]                        grant_idx,
    output arb_state_e                           dbg_state
);

    // Handshake: a beat moves only on a cycle where valid and ready are both 1.
    // valid never depends on ready; the granted source's ready is m_tready passed straight through.

    arb_state_e    state, state_nxt;
    logic [IW-1:0] last_grant;
    logic          found;
    logic [IW-1:0] pick_idx;
    logic          beat_end;

    logic [AXI_DATA_WIDTH-1:0] data_a [NUM_SRC];
    logic [KW-1:0]             keep_a [NUM_SRC];
    logic [AXI_DEST_WIDTH-1:0] dest_a [NUM_SRC];
    logic [AXI_USER_WIDTH-1:0] user_a [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_split
        assign data_a[i] = s_tdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        assign keep_a[i] = s_tkeep[i*KW +: KW];
        assign dest_a[i] = s_tdest[i*AXI_DEST_WIDTH +: AXI_DEST_WIDTH];
        assign user_a[i] = s_tuser[i*AXI_USER_WIDTH +: AXI_USER_WIDTH];
    end

    axis_rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_pick (
        .req        (s_tvalid & src_enable),
        .last_grant (last_grant),
        .found      (found),
        .index      (pick_idx)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_SRC - 1);
            grant_idx  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                grant_idx <= pick_idx;
            end
            if (state == BUSY && beat_end) begin
                last_grant <= grant_idx;
            end
        end
    end

    // Enable only gates new grants; an owner keeps the bus until its tlast is accepted.
    always_comb begin
        state_nxt = state;
        m_tdata   = '0;
        m_tkeep   = '0;
        m_tdest   = '0;
        m_tuser   = '0;
        m_tlast   = 1'b0;
        m_tvalid  = 1'b0;
        m_tid     = '0;
        s_tready  = '0;
        beat_end  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                m_tdata             = data_a[grant_idx];
                m_tkeep             = keep_a[grant_idx];
                m_tdest             = dest_a[grant_idx];
                m_tuser             = user_a[grant_idx];
                m_tlast             = s_tlast[grant_idx];
                m_tvalid            = s_tvalid[grant_idx];
                m_tid               = AXI_ID_WIDTH'(grant_idx);
                s_tready[grant_idx] = m_tready;
                beat_end            = m_tvalid & m_tready & m_tlast;
                if (beat_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_valid = (state == BUSY);
    assign dbg_state   = state;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-source packet feeders, expected-beat queue, owner and timing checks.
module tb_axis_rr_arbiter;
    import axis_arb_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int IDW = 4;
    localparam int EW  = 79;  // {last, tid[3:0], user, dest, keep[7:0], data[63:0]}

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N-1:0]    src_enable;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tdest, s_tuser, s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [IDW-1:0]  m_tid;
    logic            m_tdest, m_tuser, m_tvalid, m_tlast, m_tready;
    logic            grant_valid;
    logic [1:0]      grant_idx;
    arb_state_e      dbg_state;

    axis_rr_arbiter #(
        .NUM_SRC(N), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW),
        .AXI_DEST_WIDTH(1), .AXI_USER_WIDTH(1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .src_enable(src_enable),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tid(m_tid), .m_tdest(m_tdest),
        .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    // ---------------- bench state ----------------
    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int plen [N];
    int left [N];
    int pno  [N];
    int bno  [N];
    logic [31:0] salt;
    logic rst_edge;
    logic tgl_rdy;
    int exp_gap, prev_first, first_xfer, last_s, last_b, xfer_cnt;

    function automatic logic [EW-1:0] mk_beat(input int s, input int p, input int b, input int n);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        l = (b == n - 1);
        d = {8'(s), 8'(p), 8'(b), 8'h5A,
             (32'(s) * 32'h9E37_79B9) ^ (32'(p) * 32'h85EB_CA6B) ^ (32'(b) * 32'h0101_0101) ^ salt};
        k = l ? (8'hFF >> (b % 8)) : 8'hFF;
        return {l, 4'(s), 1'(b), 1'(s), k, d};
    endfunction

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] e);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_src();
        logic [EW-1:0] e;
        for (int s = 0; s < N; s++) begin
            e = mk_beat(s, pno[s], bno[s], plen[s]);
            s_tvalid[s]          = (left[s] > 0);
            s_tdata[s*DW +: DW]  = e[63:0];
            s_tkeep[s*KW +: KW]  = e[71:64];
            s_tdest[s]           = e[72];
            s_tuser[s]           = e[73];
            s_tlast[s]           = e[78];
        end
    endtask

    task automatic load(input int s, input int npk, input int n);
        plen[s] = n;
        left[s] = npk;
        bno[s]  = 0;
    endtask

    task automatic push_pkt(input int s, input int k, input int nb);
        for (int b = 0; b < nb; b++) exp_q.push_back(mk_beat(s, pno[s] + k, b, plen[s]));
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic monitor();
        logic [EW-1:0] obs, e;
        logic [N-1:0]  rdy_exp;
        int es, eb;
        if (!aresetn && !rst_edge) return;  // reset requested but not yet taken by the DUT
        if (rst_edge) begin
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_s_tready", s_tready, 0);
            check("rst_grant_valid", grant_valid, 0);
            check("rst_grant_idx", grant_idx, 0);
            check("rst_state", dbg_state, IDLE);
            return;
        end
        if (grant_valid) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL spurious_grant: grant_idx=%0d with no beat expected", grant_idx);
            end
            if (exp_q.size() != 0) begin
                e  = exp_q[0];
                es = int'(e[77:74]);
                rdy_exp = '0;
                rdy_exp[es] = m_tready;
                check("grant_idx", grant_idx, es);
                check("m_tid", m_tid, es);
                check("s_tready_busy", s_tready, rdy_exp);
            end
        end else begin
            check("idle_m_tvalid", m_tvalid, 0);
            check("idle_s_tready", s_tready, 0);
            check("idle_m_tid", m_tid, 0);
        end
        if (m_tvalid && m_tready) begin
            obs = {m_tlast, m_tid, m_tuser, m_tdest, m_tkeep, m_tdata};
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL extra_beat: observed=%0h with no beat expected", obs);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat", obs, e);
                es = int'(e[77:74]);
                eb = int'(e[47:40]);
                if (eb == 0) begin
                    if (exp_gap > 0 && prev_first >= 0) check("pkt_period", cyc - prev_first, exp_gap);
                    prev_first = cyc;
                end
                if (first_xfer < 0) first_xfer = cyc;
                last_s = es;
                last_b = eb;
                xfer_cnt++;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] hs;
        @(negedge aclk);
        cyc++;
        monitor();
        hs = aresetn ? (s_tvalid & s_tready) : '0;
        @(posedge aclk);
        rst_edge = !aresetn;
        #1;
        for (int s = 0; s < N; s++) begin
            if (hs[s]) begin
                bno[s]++;
                if (bno[s] == plen[s]) begin
                    bno[s] = 0;
                    pno[s]++;
                    left[s]--;
                end
            end
        end
        if (tgl_rdy) m_tready = !m_tready;
        drive_src();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL %s_timeout: observed=%0d beats outstanding expected=0", tag, exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t_rel, n, wl, n0;
        salt       = $urandom;
        aresetn    = 1'b0;
        m_tready   = 1'b1;
        tgl_rdy    = 1'b0;
        src_enable = '1;
        exp_gap    = 0;
        prev_first = -1;
        first_xfer = -1;
        last_s     = -1;
        last_b     = -1;
        xfer_cnt   = 0;
        for (int s = 0; s < N; s++) begin
            plen[s] = 1; left[s] = 0; pno[s] = 0; bno[s] = 0;
        end
        drive_src();
        repeat (2) @(posedge aclk);
        #1;
        rst_edge = 1'b1;
        tick();
        tick();

        // reset release with all four valid, then continuous 3-beat packets in rotation
        for (int s = 0; s < N; s++) load(s, 2, 3);
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < N; s++) push_pkt(s, k, 3);
        drive_src();
        aresetn    = 1'b1;
        exp_gap    = 4;
        prev_first = -1;
        t_rel      = cyc + 1;
        drain("fairness", 60);
        check("first_beat_latency", first_xfer - t_rel, 1);

        // source 1 holds the bus for 5 beats under 1010 backpressure while source 2 waits
        load(1, 1, 5);
        load(2, 1, 2);
        push_pkt(1, 0, 5);
        push_pkt(2, 0, 2);
        exp_gap = 0;
        tgl_rdy = 1'b1;
        drive_src();
        drain("lock", 40);
        tgl_rdy  = 1'b0;
        m_tready = 1'b1;

        // source 2 disabled; source 1 loses its enable mid-packet and still finishes
        src_enable = 4'b1011;
        load(0, 1, 3);
        load(1, 1, 4);
        load(2, 2, 2);
        load(3, 2, 2);
        push_pkt(3, 0, 2);
        push_pkt(0, 0, 3);
        push_pkt(1, 0, 4);
        push_pkt(3, 1, 2);
        last_s = -1;
        drive_src();
        n = 0;
        while (!(last_s == 1 && last_b == 1) && n < 60) begin
            tick();
            n++;
        end
        check("enable_mid_pkt_seen", (last_s == 1 && last_b == 1), 1);
        src_enable[1] = 1'b0;
        drain("enable", 60);

        // re-enable: the parked source 2 sends two packets back to back, with one bubble between
        src_enable = '1;
        push_pkt(2, 0, 2);
        push_pkt(2, 1, 2);
        exp_gap    = 3;
        prev_first = -1;
        drain("reenable", 40);

        // only source 3 requests: wrap from last_grant and repeat grant with one idle gap
        wl = $urandom_range(1, 4);
        load(3, 2, wl);
        push_pkt(3, 0, wl);
        push_pkt(3, 1, wl);
        exp_gap    = wl + 1;
        prev_first = -1;
        drive_src();
        drain("wrap", 40);

        // reset on the second of four beats, then source 2 alone wins from input 0 upward
        exp_gap = 0;
        load(0, 1, 4);
        push_pkt(0, 0, 1);
        drive_src();
        n0 = xfer_cnt;
        n  = 0;
        while (xfer_cnt == n0 && n < 20) begin
            tick();
            n++;
        end
        check("rstmid_first_beat_seen", xfer_cnt - n0, 1);
        aresetn = 1'b0;
        tick();
        left[0] = 0;
        bno[0]  = 0;
        load(2, 1, 2);
        push_pkt(2, 0, 2);
        aresetn = 1'b1;
        drive_src();
        drain("rst_mid", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
